// File: rtl/bus_pack_pkg.sv
// Shared definitions for the bus_pack_stream lane packer.
//   state_e    : FILL/HOLD state encoding
//   count_w()  : width of a lane count covering 0..LANES
//   lane_slot(): lane slot a given lane index lands in, honouring REVERSE
package bus_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int count_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int lane_slot(input int idx, input int lanes, input int reverse);
        return (reverse != 0) ? (lanes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/bus_pack_lane_place.sv
// Combinational lane writer: copies word_i to word_o with lane_i written
// into the slot chosen by idx_i (slot idx_i, or LANES-1-idx_i when REVERSE).
//   word_i : current word
//   lane_i : lane payload
//   idx_i  : lane number within the word (0-based)
//   word_o : word with the lane placed
module bus_pack_lane_place
    import bus_pack_pkg::*;
#(
    parameter int LANE_W  = 1,
    parameter int LANES   = 32,
    parameter int REVERSE = 0,
    parameter int IDX_W   = 6
) (
    input  logic [LANE_W*LANES-1:0] word_i,
    input  logic [LANE_W-1:0]       lane_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [LANE_W*LANES-1:0] word_o
);

    int slot;

    always_comb begin
        slot   = lane_slot(int'(idx_i), LANES, REVERSE);
        word_o = word_i;
        for (int s = 0; s < LANES; s++) begin
            if (s == slot) begin
                word_o[s*LANE_W +: LANE_W] = lane_i;
            end
        end
    end

endmodule

// File: rtl/bus_pack_stream.sv
// Packs a stream of LANE_W-bit lanes into LANE_W*LANES-bit words with a
// valid/ready handshake on both sides and a flush for partial words.
//   system1000 / system1000_rstn : clock, async active-low reset
//   in_data/in_valid/in_ready    : lane input handshake
//   flush                        : emit the partial word
//   out_data/out_count/out_valid/out_ready : packed word output handshake
//
// state | meaning
// FILL  | accumulating lanes, out_valid=0, outputs show the partial word
// HOLD  | word presented, waiting for out_ready
module bus_pack_stream
    import bus_pack_pkg::*;
#(
    parameter int LANE_W  = 1,
    parameter int LANES   = 32,
    parameter int REVERSE = 0
) (
    input  logic                          system1000,
    input  logic                          system1000_rstn,
    input  logic [LANE_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [LANE_W*LANES-1:0]       out_data,
    output logic [count_w(LANES)-1:0]     out_count,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int CNT_W = count_w(LANES);
    localparam int W     = LANE_W * LANES;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     data_q, data_d;

    logic             accept;
    logic [W-1:0]     place_base;
    logic [W-1:0]     placed;
    logic [CNT_W-1:0] place_idx;

    assign in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = data_q;
    assign out_count = cnt_q;
    assign out_valid = (state_q == HOLD);

    // In HOLD an accepted lane starts a fresh word, so it lands on an empty
    // word at index 0 rather than on the word being emitted.
    assign place_base = (state_q == HOLD) ? '0 : data_q;
    assign place_idx  = (state_q == HOLD) ? '0 : cnt_q;

    bus_pack_lane_place #(
        .LANE_W  (LANE_W),
        .LANES   (LANES),
        .REVERSE (REVERSE),
        .IDX_W   (CNT_W)
    ) u_place (
        .word_i (place_base),
        .lane_i (in_data),
        .idx_i  (place_idx),
        .word_o (placed)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    data_d = placed;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if ((cnt_q == LAST_IDX) || flush) begin
                        state_d = HOLD;
                    end
                end else if (flush && (cnt_q != '0)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        data_d  = placed;
                        cnt_d   = CNT_W'(1);
                        // With single-lane words the new lane is already a full word.
                        state_d = (LANES == 1) ? HOLD : FILL;
                    end else begin
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_bus_pack_stream.sv
module tb_bus_pack_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // A (8x4, LSB first) and B (8x4, MSB first) share all inputs.
    logic [7:0]  in_data;
    logic        in_valid, flush, out_ready;
    logic        a_in_ready, b_in_ready, a_out_valid, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [2:0]  a_out_count, b_out_count;

    // C: 1x32, LSB first.
    logic        c_in_data, c_in_valid, c_flush, c_out_ready, c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [5:0]  c_out_count;

    bus_pack_stream #(.LANE_W(8), .LANES(4), .REVERSE(0)) u_a (
        .system1000(clk), .system1000_rstn(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .flush(flush), .out_data(a_out_data), .out_count(a_out_count),
        .out_valid(a_out_valid), .out_ready(out_ready));

    bus_pack_stream #(.LANE_W(8), .LANES(4), .REVERSE(1)) u_b (
        .system1000(clk), .system1000_rstn(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .flush(flush), .out_data(b_out_data), .out_count(b_out_count),
        .out_valid(b_out_valid), .out_ready(out_ready));

    bus_pack_stream #(.LANE_W(1), .LANES(32), .REVERSE(0)) u_c (
        .system1000(clk), .system1000_rstn(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .flush(c_flush), .out_data(c_out_data), .out_count(c_out_count),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    // lanes: lane k in byte k; fm: 0 no flush, 1 flush with last lane, 2 flush in a later cycle
    typedef struct {
        logic [31:0] lanes;
        int          n;
        int          fm;
        logic [31:0] ea;
        logic [31:0] eb;
        int          ec;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: a word is compared when its handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_word", a_out_data, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_word_data", a_out_data, e.d);
                chk("a_word_count", 32'(a_out_count), 32'(e.c));
            end
        end
        if (rst_n && b_out_valid && out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_word", b_out_data, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_word_data", b_out_data, e.d);
                chk("b_word_count", 32'(b_out_count), 32'(e.c));
            end
        end
    end

    task automatic feed(input logic [31:0] lanes, input int n, input int fm);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = lanes[8*k +: 8];
            flush    = (fm == 1) && (k == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (fm == 2) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic push(input logic [31:0] ea, input logic [31:0] eb, input int ec);
        qa.push_back('{d: ea, c: ec});
        qb.push_back('{d: eb, c: ec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[6];
        vt[0] = '{lanes: 32'h44332211, n: 4, fm: 0, ea: 32'h44332211, eb: 32'h11223344, ec: 4};
        vt[1] = '{lanes: 32'h0000BBAA, n: 2, fm: 2, ea: 32'h0000BBAA, eb: 32'hAABB0000, ec: 2};
        vt[2] = '{lanes: 32'h00030201, n: 3, fm: 1, ea: 32'h00030201, eb: 32'h01020300, ec: 3};
        vt[3] = '{lanes: 32'h0000005A, n: 1, fm: 2, ea: 32'h0000005A, eb: 32'h5A000000, ec: 1};
        vt[4] = '{lanes: 32'hEFBEADDE, n: 4, fm: 1, ea: 32'hEFBEADDE, eb: 32'hDEADBEEF, ec: 4};
        vt[5] = '{lanes: 32'h00000000, n: 0, fm: 2, ea: 32'h0,        eb: 32'h0,        ec: 0};

        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        c_in_data = 1'b0; c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_data", a_out_data, 32'd0);
        chk("rst_a_count", 32'(a_out_count), 32'd0);
        chk("rst_c_data", c_out_data, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_in_ready_after_rst", 32'(a_in_ready), 32'd1);
        chk("c_in_ready_after_rst", 32'(c_in_ready), 32'd1);

        // Table vectors on A/B
        for (int i = 0; i < 6; i++) begin
            if (vt[i].ec > 0) push(vt[i].ea, vt[i].eb, vt[i].ec);
            feed(vt[i].lanes, vt[i].n, vt[i].fm);
            if (vt[i].ec == 0) begin
                for (int j = 0; j < 3; j++) begin
                    chk("flush_empty_no_valid", 32'(a_out_valid | b_out_valid), 32'd0);
                    @(posedge clk); #1;
                end
            end
            drain($sformatf("vec%0d_drain", i));
            @(posedge clk); #1;
        end

        // Full 1x32 word, alternating bits
        for (int k = 0; k < 32; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = (k % 2 == 0);
            if (k == 31) chk("c_valid_before_last", 32'(c_out_valid), 32'd0);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        chk("c_full_valid", 32'(c_out_valid), 32'd1);
        chk("c_full_data", c_out_data, 32'h55555555);
        chk("c_full_count", 32'(c_out_count), 32'd32);
        @(posedge clk); #1;
        chk("c_consumed", 32'(c_out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        push(32'h44332211, 32'h11223344, 4);
        feed(32'h44332211, 4, 0);
        for (int j = 0; j < 5; j++) begin
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_a_valid", 32'(a_out_valid), 32'd1);
            chk("bp_a_data", a_out_data, 32'h44332211);
            chk("bp_b_data", b_out_data, 32'h11223344);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hCC;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        chk("bp_next_valid", 32'(a_out_valid), 32'd0);
        chk("bp_next_count", 32'(a_out_count), 32'd1);
        chk("bp_next_a_data", a_out_data, 32'h000000CC);
        chk("bp_next_b_data", b_out_data, 32'hCC000000);
        chk("bp_word_consumed", 32'(qa.size()), 32'd0);
        push(32'h000000CC, 32'hCC000000, 1);
        feed(32'h0, 0, 2);
        drain("bp_drain");

        // Reset mid-word
        feed(32'h00008877, 2, 0);
        chk("mid_partial_data", a_out_data, 32'h00008877);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_data", a_out_data, 32'd0);
        chk("mid_rst_a_count", 32'(a_out_count), 32'd0);
        chk("mid_rst_b_data", b_out_data, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_in_ready", 32'(a_in_ready), 32'd1);
        push(32'h04030201, 32'h01020304, 4);
        feed(32'h04030201, 4, 0);
        drain("mid_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_pack_stream.md
BUS_PACK_STREAM -- requirements
Module: bus_pack_stream

Interface
REQ-001 SHALL have parameter LANE_W, default 1, bits per input lane.
REQ-002 SHALL have parameter LANES, default 32, lanes per output word.
REQ-003 SHALL have parameter REVERSE, default 0; 0 places the first lane at the LSB, 1 places the first lane at the MSB.
REQ-004 SHALL have port system1000, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port system1000_rstn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port in_data, input, LANE_W, lane payload.
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a lane this cycle.
REQ-009 SHALL have port flush, input, 1, request to emit the partial word.
REQ-010 SHALL have port out_data, output, LANE_W*LANES, packed word.
REQ-011 SHALL have port out_count, output, clog2(LANES+1), number of valid lanes in out_data.
REQ-012 SHALL have port out_valid, output, 1, out_data/out_count valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the word.

Function
REQ-014 SHALL have two states: FILL (accumulating) and HOLD (word presented).
REQ-015 SHALL treat a lane as accepted iff in_valid && in_ready at a rising edge.
REQ-016 SHALL write accepted lane number k (0-based within the word) to out_data[k*LANE_W +: LANE_W] when REVERSE=0, and to lane slot LANES-1-k when REVERSE=1.
REQ-017 SHALL hold every unwritten lane slot at zero.
REQ-018 SHALL drive in_ready=1 in FILL, and in HOLD SHALL drive in_ready=out_ready.
REQ-019 SHALL transition FILL->HOLD on the edge that accepts lane LANES-1.
  - out_valid=1 and out_count=LANES from the next cycle (1-cycle latency).
REQ-020 SHALL, in FILL with fill count>0 and flush=1 and no lane accepted, transition to HOLD with out_count=fill count.
REQ-021 SHALL, on flush plus an accepted lane in the same cycle, include that lane first, then emit.
  - If that lane completes the word, out_count=LANES.
REQ-022 SHALL ignore flush in FILL with fill count 0 and no accepted lane, and SHALL ignore flush in HOLD.
REQ-023 SHALL, in HOLD, keep out_data/out_count/out_valid stable until out_valid && out_ready.
REQ-024 SHALL, on that output handshake, clear the word and count.
  - A lane accepted in the same cycle SHALL become lane 0 of the next word (count=1, state FILL).
  - Otherwise state FILL with count 0.
REQ-025 SHALL, when LANES=1, emit every accepted lane as a full word with no FILL dwell beyond one cycle.
REQ-026 SHALL drive out_valid=0 in FILL; out_data/out_count in FILL reflect the partial accumulation.

Reset
REQ-027 SHALL, while system1000_rstn=0, force state=FILL, count=0, out_data=0, out_count=0, out_valid=0, independent of clock.
REQ-028 SHALL discard any partial or held word on reset mid-operation; the first lane after reset release is lane 0.
REQ-029 SHALL drive in_ready=1 from the first cycle after reset release.

Structure
REQ-030 SHALL place the FILL/HOLD state encoding and the count-width function clog2(LANES+1) in the shared package bus_pack_pkg.
REQ-031 SHALL use one sub-module, bus_pack_lane_place, that maps (lane index, REVERSE) to a bit offset and writes the lane (combinational).
REQ-032 SHALL keep all registers in bus_pack_stream.

Verification
REQ-033 SHALL cover full word: LANE_W=1, LANES=32, REVERSE=0, feed 32 bits 1,0,1,0,... back-to-back with out_ready=1 -> one cycle after the 32nd accept, out_valid=1, out_data=0x55555555, out_count=32.
REQ-034 SHALL cover reversed order: LANE_W=8, LANES=4, REVERSE=1, lanes 0x11,0x22,0x33,0x44 -> out_data=0x11223344; with REVERSE=0 -> 0x44332211.
REQ-035 SHALL cover flush: LANE_W=8, LANES=4, lanes 0xAA,0xBB then flush -> out_data=0x0000BBAA, out_count=2; flush at count 0 -> no out_valid.
REQ-036 SHALL cover backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_data stable and in_ready=0; then out_ready=1 with in_valid=1, in_data=0xCC -> word consumed and next word count=1, slot0=0xCC.
REQ-037 SHALL cover reset mid-word: 2 lanes accepted, pulse system1000_rstn low asynchronously -> outputs 0 immediately; next 4 lanes form a full word without stale data.
